// File: rtl/nn_accel_arbiter.sv
// nn_accel_arbiter: shares one NN accelerator pipeline between NUM_REQ requesters.
// Round-robin grant into a registered request stage; a tag FIFO remembers the
// issuing requester so in-order results are routed back to it.
// Optional macro NN_ARB_PRIO0_EN: requester 0 has fixed priority, round-robin
// covers requesters 1..NUM_REQ-1 only.
module nn_accel_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned RES_W     = 32,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          acc_valid,
    output logic [DATA_W-1:0]             acc_data,
    input  logic                          acc_ready,
    input  logic                          acc_res_valid,
    input  logic [RES_W-1:0]              acc_res_data,
    output logic                          acc_res_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [RES_W-1:0]              rsp_data,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [$clog2(TAG_DEPTH):0]    outstanding,
    output logic                          err_orphan
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic [1:0] {IDLE, ISSUE, FULL} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  acc_data_q, acc_data_d;
    idx_t               rr_q, rr_d;
    logic [PTR_W-1:0]   wr_q, rd_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q;
    idx_t               tag_mem [TAG_DEPTH];

    idx_t               winner;
    idx_t               next_idx;
    idx_t               head;
    logic               found;
    int unsigned        pos;
`ifdef NN_ARB_PRIO0_EN
    int unsigned        start;
`endif
    logic               fifo_full;
    logic               fifo_empty;
    logic               load;
    logic               can_issue;
    logic               push;
    logic               pop;

    // Winner search: first valid requester at or after rr_q, wrapping
    always_comb begin
        winner = '0;
        found  = 1'b0;
        pos    = 0;
`ifdef NN_ARB_PRIO0_EN
        start  = 0;
        if (req_valid[0]) begin
            winner = '0;
            found  = 1'b1;
        end else begin
            // Rotation skips index 0; a pointer of 0 starts the scan at 1
            start = (rr_q == '0) ? 1 : int'(rr_q);
            for (int unsigned k = 0; k < NUM_REQ - 1; k++) begin
                pos = start + k;
                if (pos >= NUM_REQ) pos = pos - (NUM_REQ - 1);
                if (!found && req_valid[idx_t'(pos)]) begin
                    winner = idx_t'(pos);
                    found  = 1'b1;
                end
            end
        end
`else
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = int'(rr_q) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (!found && req_valid[idx_t'(pos)]) begin
                winner = idx_t'(pos);
                found  = 1'b1;
            end
        end
`endif
    end

    assign fifo_full  = (cnt_q == CNT_W'(TAG_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign acc_valid  = (state_q == ISSUE);
    assign load       = !acc_valid || acc_ready;
    assign can_issue  = !reset && load && !fifo_full && (|req_valid);
    assign req_ready  = {{(NUM_REQ-1){1'b0}}, can_issue} << winner;
    assign next_idx   = (winner == idx_t'(NUM_REQ - 1)) ? '0 : winner + idx_t'(1);

    assign head          = tag_mem[rd_q];
    assign push          = can_issue;
    assign pop           = !fifo_empty && acc_res_valid && rsp_ready[head];
    assign rsp_valid     = fifo_empty ? '0 : ({{(NUM_REQ-1){1'b0}}, acc_res_valid} << head);
    assign acc_res_ready = fifo_empty ? 1'b1 : rsp_ready[head];
    assign rsp_data      = acc_res_data;

    assign acc_data    = acc_data_q;
    assign outstanding = cnt_q;
    assign err_orphan  = err_q;

    // Next payload, round-robin pointer and occupancy
    always_comb begin
        acc_data_d = acc_data_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        if (can_issue) begin
            acc_data_d = req_data[winner*DATA_W +: DATA_W];
`ifdef NN_ARB_PRIO0_EN
            if (winner != '0) rr_d = next_idx;
`else
            rr_d = next_idx;
`endif
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Next FSM state; FULL is judged on post-cycle occupancy so it implies outstanding=TAG_DEPTH
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (can_issue) state_d = ISSUE;
            end
            ISSUE: begin
                if (acc_ready && !can_issue) begin
                    state_d = (cnt_d == CNT_W'(TAG_DEPTH)) ? FULL : IDLE;
                end
            end
            FULL: begin
                if (pop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_data_q <= '0;
            rr_q       <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_data_q <= acc_data_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            err_q      <= fifo_empty && acc_res_valid;
            if (push) wr_q <= wr_q + PTR_W'(1);
            if (pop)  rd_q <= rd_q + PTR_W'(1);
        end
    end

    // Tag storage; validity is tracked by the pointers, so no reset needed
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_q] <= winner;
    end

endmodule

// File: tb/tb_nn_accel_arbiter.sv
// Randomized and directed bench for nn_accel_arbiter against a queue-based model.
module tb_nn_accel_arbiter;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int RW    = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              acc_valid;
    logic [DW-1:0]     acc_data;
    logic              acc_ready;
    logic              acc_res_valid;
    logic [RW-1:0]     acc_res_data;
    logic              acc_res_ready;
    logic [N-1:0]      rsp_valid;
    logic [RW-1:0]     rsp_data;
    logic [N-1:0]      rsp_ready;
    logic [2:0]        outstanding;
    logic              err_orphan;

    nn_accel_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (DW),
        .RES_W     (RW),
        .TAG_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .acc_valid     (acc_valid),
        .acc_data      (acc_data),
        .acc_ready     (acc_ready),
        .acc_res_valid (acc_res_valid),
        .acc_res_data  (acc_res_data),
        .acc_res_ready (acc_res_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_ready     (rsp_ready),
        .outstanding   (outstanding),
        .err_orphan    (err_orphan)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_q[$];
    bit          m_av;
    logic [DW-1:0] m_ad;
    int          m_rr;
    bit          m_err;

    // Observed values captured in the last step
    logic [N-1:0]  s_req_ready;
    logic [N-1:0]  s_rsp_valid;
    logic          s_arr;
    logic          s_av;
    logic [DW-1:0] s_ad;
    logic [2:0]    s_out;
    logic          s_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Choose the valid requester closest (cyclically, upward) to the pointer
    function automatic int pick(input logic [N-1:0] rv, input int rr);
        int best;
        int bestd;
        int d;
        best  = 0;
        bestd = N + 1;
`ifdef NN_ARB_PRIO0_EN
        if (rv[0]) return 0;
        for (int i = 1; i < N; i++) begin
            d = (i - rr + N) % N;
            if (((rv >> i) & N'(1)) != 0 && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            d = (i - rr + N) % N;
            if (((rv >> i) & N'(1)) != 0 && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
`endif
        return best;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_av  = 0;
        m_ad  = '0;
        m_rr  = 0;
        m_err = 0;
    endtask

    // One clock cycle: drive, check against the model, advance the model
    task automatic step(input logic [N-1:0] rv, input logic [N*DW-1:0] rd, input bit ar,
                        input bit resv, input logic [RW-1:0] resd, input logic [N-1:0] rr);
        bit           load;
        bit           can;
        bit           pop;
        bit           orph;
        int           win;
        int           h;
        logic [N-1:0] e_rr;
        logic [N-1:0] e_rv;
        bit           e_arr;
        @(negedge clk);
        req_valid     = rv;
        req_data      = rd;
        acc_ready     = ar;
        acc_res_valid = resv;
        acc_res_data  = resd;
        rsp_ready     = rr;
        #1;
        load  = !m_av || ar;
        can   = load && (m_q.size() < DEPTH) && (rv != '0);
        win   = pick(rv, m_rr);
        e_rr  = can ? (N'(1) << win) : '0;
        e_rv  = '0;
        e_arr = 1'b1;
        pop   = 0;
        orph  = 0;
        if (m_q.size() > 0) begin
            h     = m_q[0];
            e_rv  = resv ? (N'(1) << h) : '0;
            e_arr = ((rr >> h) & N'(1)) != 0;
            pop   = resv && e_arr;
        end else begin
            orph = resv;
        end
        s_req_ready = req_ready;
        s_rsp_valid = rsp_valid;
        s_arr       = acc_res_ready;
        s_av        = acc_valid;
        s_ad        = acc_data;
        s_out       = outstanding;
        s_err       = err_orphan;
        check_eq("req_ready",     64'(req_ready),     64'(e_rr));
        check_eq("acc_valid",     64'(acc_valid),     64'(m_av));
        check_eq("acc_data",      64'(acc_data),      64'(m_ad));
        check_eq("outstanding",   64'(outstanding),   64'(m_q.size()));
        check_eq("err_orphan",    64'(err_orphan),    64'(m_err));
        check_eq("rsp_valid",     64'(rsp_valid),     64'(e_rv));
        check_eq("acc_res_ready", 64'(acc_res_ready), 64'(e_arr));
        check_eq("rsp_data",      64'(rsp_data),      64'(resd));
        @(posedge clk);
        if (pop) void'(m_q.pop_front());
        if (can) begin
            m_q.push_back(win);
            m_av = 1;
            m_ad = rd[win*DW +: DW];
`ifdef NN_ARB_PRIO0_EN
            if (win != 0) m_rr = (win + 1) % N;
`else
            m_rr = (win + 1) % N;
`endif
        end else if (load) begin
            m_av = 0;
        end
        m_err = orph;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid     = '1;
        acc_ready     = 1'b0;
        acc_res_valid = 1'b0;
        reset         = 1'b1;
        #1;
        check_eq("rst_acc_valid",   64'(acc_valid),   64'(0));
        check_eq("rst_outstanding", 64'(outstanding), 64'(0));
        check_eq("rst_req_ready",   64'(req_ready),   64'(0));
        @(posedge clk);
        #1;
        check_eq("rst_req_ready_hold", 64'(req_ready), 64'(0));
        check_eq("rst_acc_data",       64'(acc_data),  64'(0));
        @(negedge clk);
        req_valid = '0;
        reset     = 1'b0;
        model_reset();
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (((v >> i) & N'(1)) != 0) r = i;
        return r;
    endfunction

    initial begin
        int order[5];
        int issues;
        logic [N*DW-1:0] d;
        order = '{0, 1, 2, 3, 0};

        reset         = 1'b1;
        req_valid     = '0;
        req_data      = '0;
        acc_ready     = 1'b0;
        acc_res_valid = 1'b0;
        acc_res_data  = '0;
        rsp_ready     = '0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Round-robin fairness with immediate result return
        for (int k = 0; k < 5; k++) begin
            step('1, {$urandom(), $urandom()}, 1'b1, m_q.size() > 0, $urandom(), '1);
            check_eq("rr_grant", 64'(onehot_idx(s_req_ready)), 64'(order[k]));
            if (k >= 1) check_eq("rr_route", 64'(s_rsp_valid), 64'(N'(1) << order[k-1]));
        end

        // Backpressure holds the captured payload
        d = {$urandom(), $urandom()};
        d[DW-1:0] = 16'hBEEF;
        step(4'b0001, d, 1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 5; k++) begin
            step('1, {$urandom(), $urandom()}, 1'b0, 1'b0, '0, '0);
            check_eq("bp_data",      64'(s_ad),        64'(16'hBEEF));
            check_eq("bp_valid",     64'(s_av),        64'(1));
            check_eq("bp_req_ready", 64'(s_req_ready), 64'(0));
        end
        step(4'b0110, {$urandom(), $urandom()}, 1'b1, 1'b0, '0, '0);
        check_eq("bp_release", 64'(s_req_ready), 64'(4'b0010));

        // Reset while a request is held
        step('1, {$urandom(), $urandom()}, 1'b0, 1'b0, '0, '0);
        do_reset();

        // Tag FIFO fills after exactly DEPTH issues
        issues = 0;
        for (int k = 0; k < 6; k++) begin
            step('1, {$urandom(), $urandom()}, 1'b1, 1'b0, '0, '0);
            if (s_req_ready != '0) issues++;
        end
        check_eq("full_issues", 64'(issues), 64'(DEPTH));
        check_eq("full_outstanding", 64'(s_out), 64'(DEPTH));
        step('1, {$urandom(), $urandom()}, 1'b1, 1'b1, $urandom(), '1);
        check_eq("full_pop_no_push", 64'(s_req_ready), 64'(0));
        step('1, {$urandom(), $urandom()}, 1'b1, 1'b0, '0, '0);
        check_eq("full_after_pop", 64'(s_req_ready != '0), 64'(1));
        do_reset();

        // Routing with result backpressure, then orphan
        step(4'b0100, {$urandom(), $urandom()}, 1'b1, 1'b0, '0, '0);
        step(4'b0001, {$urandom(), $urandom()}, 1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 2; k++) begin
            step('0, '0, 1'b1, 1'b1, 32'h1234_0000, 4'b1011);
            check_eq("route_hold_valid", 64'(s_rsp_valid), 64'(4'b0100));
            check_eq("route_hold_ready", 64'(s_arr),       64'(0));
        end
        step('0, '0, 1'b1, 1'b1, 32'h1234_0000, 4'b0100);
        check_eq("route_pop_ready", 64'(s_arr), 64'(1));
        step('0, '0, 1'b1, 1'b1, 32'h5678_0000, 4'b0001);
        check_eq("route_next_valid", 64'(s_rsp_valid), 64'(4'b0001));
        step('0, '0, 1'b1, 1'b1, 32'hDEAD_0000, '0);
        check_eq("orphan_ready", 64'(s_arr), 64'(1));
        step('0, '0, 1'b1, 1'b0, '0, '0);
        check_eq("orphan_pulse", 64'(s_err), 64'(1));
        step('0, '0, 1'b1, 1'b0, '0, '0);
        check_eq("orphan_clear", 64'(s_err), 64'(0));

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            step(N'($urandom()), {$urandom(), $urandom()}, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) != 0), $urandom(), N'($urandom()));
        end

`ifdef NN_ARB_PRIO0_EN
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(4'b0011, {$urandom(), $urandom()}, 1'b1, m_q.size() > 0, $urandom(), '1);
            check_eq("prio0_grant", 64'(s_req_ready), 64'(4'b0001));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
